// File: rtl/wrapper_packet_construct.sv
// rtl/wrapper_packet_construct.sv - assembles 32-bit register writes into a packet and streams it out
module wrapper_packet_construct #(
    parameter int ADDRWIDTH   = 12,
    parameter int PACKETWIDTH = 512
) (
    input  logic                   hclk,
    input  logic                   hresetn,
    input  logic [ADDRWIDTH-1:0]   addr,
    input  logic                   read_en,
    input  logic                   write_en,
    input  logic [3:0]             byte_strobe,
    input  logic [31:0]            wdata,
    output logic [31:0]            rdata,
    output logic                   wready,
    output logic                   rready,
    output logic [PACKETWIDTH-1:0] packet_data,
    output logic                   packet_last,
    output logic                   packet_valid,
    input  logic                   packet_ready
);

    localparam int NWORDS = PACKETWIDTH / 32;
    localparam int WIDXW  = ADDRWIDTH - 2;
    localparam int IDXW   = $clog2(NWORDS);

    typedef enum logic {
        FILL,
        SEND
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [31:0]       buffer [NWORDS];
    logic              last_flag;
    logic [WIDXW-1:0]  widx;
    logic [IDXW-1:0]   bidx;
    logic              is_buf;
    logic              is_status;
    logic              is_final;
    logic              wr_done;
    logic              handshake;

    // read_en and the byte offset carry no information for this register map
    logic unused_inputs;
    assign unused_inputs = &{1'b0, read_en, addr[1:0]};

    assign widx      = addr[ADDRWIDTH-1:2];
    assign bidx      = widx[IDXW-1:0];
    assign is_buf    = widx < WIDXW'(NWORDS);
    assign is_status = widx == WIDXW'(NWORDS);
    assign is_final  = widx == WIDXW'(NWORDS - 1);

    assign wready       = (state == FILL);
    assign rready       = 1'b1;
    assign packet_valid = (state == SEND);
    assign packet_last  = packet_valid & last_flag;
    assign wr_done      = write_en & wready;
    assign handshake    = packet_valid & packet_ready;

    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            FILL: if (wr_done && is_final) state_next = SEND;
            SEND: if (packet_ready) state_next = FILL;
            default: state_next = FILL;
        endcase
    end

    // Buffer and last_flag are wiped on handshake so the next packet starts from zeros
    always_ff @(posedge hclk) begin
        if (!hresetn || handshake) begin
            for (int i = 0; i < NWORDS; i++) begin
                buffer[i] <= '0;
            end
            last_flag <= 1'b0;
        end else if (wr_done) begin
            if (is_buf) begin
                for (int b = 0; b < 4; b++) begin
                    if (byte_strobe[b]) begin
                        buffer[bidx][8*b +: 8] <= wdata[8*b +: 8];
                    end
                end
            end
            if (is_status && byte_strobe[0]) begin
                last_flag <= wdata[1];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NWORDS; i++) begin
            packet_data[32*i +: 32] = buffer[i];
        end
    end

    always_comb begin
        rdata = '0;
        if (is_buf) begin
            rdata = buffer[bidx];
        end else if (is_status) begin
            rdata = {30'b0, last_flag, packet_valid};
        end
    end

endmodule

// File: tb/tb_wrapper_packet_construct.sv
// tb/tb_wrapper_packet_construct.sv - scoreboard bench for wrapper_packet_construct
module tb_wrapper_packet_construct;

    localparam int AW = 12;
    localparam int PW = 256;
    localparam int N  = PW / 32;

    logic          hclk = 1'b0;
    logic          hresetn;
    logic [AW-1:0] addr;
    logic          read_en;
    logic          write_en;
    logic [3:0]    byte_strobe;
    logic [31:0]   wdata;
    logic [31:0]   rdata;
    logic          wready;
    logic          rready;
    logic [PW-1:0] packet_data;
    logic          packet_last;
    logic          packet_valid;
    logic          packet_ready;

    wrapper_packet_construct #(.ADDRWIDTH(AW), .PACKETWIDTH(PW)) dut (
        .hclk(hclk), .hresetn(hresetn), .addr(addr), .read_en(read_en),
        .write_en(write_en), .byte_strobe(byte_strobe), .wdata(wdata),
        .rdata(rdata), .wready(wready), .rready(rready),
        .packet_data(packet_data), .packet_last(packet_last),
        .packet_valid(packet_valid), .packet_ready(packet_ready)
    );

    always #5 hclk = ~hclk;

    // Reference model: register file view of what the bus has written
    logic [31:0]   m_mem [N];
    logic          m_last;
    logic          m_pending;
    logic [PW-1:0] q_data [$];
    logic          q_last [$];
    int            n_cmp = 0;
    int            n_err = 0;
    int            rdy_mode = 2;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic m_clear();
        for (int i = 0; i < N; i++) m_mem[i] = '0;
        m_last    = 1'b0;
        m_pending = 1'b0;
    endtask

    function automatic logic [31:0] m_read(input int w);
        if (w < N) return m_mem[w];
        if (w == N) return {30'b0, m_last, m_pending};
        return 32'h0;
    endfunction

    // Callers are always positioned 1 time unit after a rising edge
    task automatic do_write(input int w, input logic [31:0] d, input logic [3:0] s, output int stalls);
        logic [AW-3:0]   wv;
        logic [PW-1:0]   p;
        wv          = w[AW-3:0];
        addr        = {wv, 2'($urandom)};
        wdata       = d;
        byte_strobe = s;
        write_en    = 1'b1;
        stalls      = 0;
        forever begin
            @(negedge hclk);
            chk("wready", {31'b0, wready}, {31'b0, !m_pending});
            if (wready) break;
            stalls++;
            if (stalls > 500) begin
                n_cmp++;
                n_err++;
                $display("FAIL write_timeout: got no wready expected wready within 500 cycles");
                break;
            end
        end
        @(posedge hclk);
        if (wready || stalls <= 500) begin
            if (w < N) begin
                for (int b = 0; b < 4; b++)
                    if (s[b]) m_mem[w][8*b +: 8] = d[8*b +: 8];
            end else if (w == N && s[0]) begin
                m_last = d[1];
            end
            if (w == N - 1) begin
                for (int i = 0; i < N; i++) p[32*i +: 32] = m_mem[i];
                q_data.push_back(p);
                q_last.push_back(m_last);
                m_pending = 1'b1;
            end
        end
        #1;
        write_en = 1'b0;
    endtask

    task automatic wr(input int w, input logic [31:0] d, input logic [3:0] s);
        int st;
        do_write(w, d, s, st);
    endtask

    task automatic do_read(input int w);
        logic [AW-3:0] wv;
        wv      = w[AW-3:0];
        addr    = {wv, 2'($urandom)};
        read_en = 1'b1;
        @(negedge hclk);
        chk("rready", {31'b0, rready}, 32'h1);
        chk($sformatf("rdata[w%0d]", w), rdata, m_read(w));
        @(posedge hclk);
        #1;
        read_en = 1'b0;
    endtask

    task automatic do_reset();
        packet_ready = 1'b0;
        hresetn      = 1'b0;
        @(posedge hclk);
        #1;
        hresetn = 1'b1;
        m_clear();
        q_data.delete();
        q_last.delete();
    endtask

    // Monitor: pops expected packets on each handshake
    initial begin
        forever begin
            @(negedge hclk);
            if (hresetn) begin
                chk("packet_valid", {31'b0, packet_valid}, {31'b0, m_pending});
                if (packet_valid && packet_ready) begin
                    n_cmp++;
                    if (q_data.size() == 0) begin
                        n_err++;
                        $display("FAIL unexpected_packet: got %h expected no packet", packet_data);
                    end else begin
                        logic [PW-1:0] ed;
                        logic          el;
                        ed = q_data.pop_front();
                        el = q_last.pop_front();
                        if (packet_data !== ed) begin
                            n_err++;
                            $display("FAIL packet_data: got %h expected %h", packet_data, ed);
                        end
                        chk("packet_last", {31'b0, packet_last}, {31'b0, el});
                    end
                    @(posedge hclk);
                    m_clear();
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge hclk);
            #1;
            if (rdy_mode == 0) packet_ready = 1'b0;
            else if (rdy_mode == 1) packet_ready = ($urandom_range(0, 2) == 0);
        end
    end

    initial begin
        int st;
        m_clear();
        hresetn = 1'b0; addr = '0; read_en = 1'b0; write_en = 1'b0;
        byte_strobe = '0; wdata = '0; packet_ready = 1'b0;
        repeat (3) @(posedge hclk);
        #1;
        hresetn = 1'b1;

        // Reset state
        @(negedge hclk);
        chk("rst_wready", {31'b0, wready}, 32'h1);
        chk("rst_valid", {31'b0, packet_valid}, 32'h0);
        chk("rst_rdata0", rdata, 32'h0);
        @(posedge hclk); #1;
        do_read(0);
        do_read(N);

        // Full fill with downstream stalled
        for (int i = 0; i < N; i++) wr(i, 32'h11111111 + i, 4'hF);
        chk("fill_valid", {31'b0, packet_valid}, 32'h1);
        do_read(N);
        chk("status_val", m_read(N), 32'h1);
        for (int i = 0; i < N; i++) do_read(i);

        // Write held across the pending packet
        fork
            do_write(0, 32'hCAFEF00D, 4'hF, st);
            begin
                repeat (4) @(posedge hclk);
                #1 packet_ready = 1'b1;
                @(posedge hclk);
                #1 packet_ready = 1'b0;
            end
        join
        chk("stall_seen", {31'b0, st > 0}, 32'h1);
        for (int i = 0; i < N; i++) do_read(i);

        // Byte-lane merge
        wr(2, 32'hAABBCCDD, 4'hF);
        wr(2, 32'h00000011, 4'b0001);
        do_read(2);
        chk("merge_val", m_mem[2], 32'hAABBCC11);

        // Last flag, then a packet without it
        wr(N, 32'h2, 4'h1);
        do_read(N);
        for (int i = 0; i < N; i++) wr(i, $urandom, 4'hF);
        packet_ready = 1'b1;
        repeat (2) @(posedge hclk);
        #1 packet_ready = 1'b0;
        for (int i = 0; i < N; i++) wr(i, $urandom, 4'hF);
        packet_ready = 1'b1;
        repeat (2) @(posedge hclk);
        #1 packet_ready = 1'b0;

        // Reset while a packet is pending
        for (int i = 0; i < N; i++) wr(i, $urandom | 32'h1, 4'hF);
        @(negedge hclk);
        chk("pre_rst_valid", {31'b0, packet_valid}, 32'h1);
        @(posedge hclk); #1;
        do_reset();
        @(negedge hclk);
        chk("post_rst_valid", {31'b0, packet_valid}, 32'h0);
        @(posedge hclk); #1;
        for (int i = 0; i <= N; i++) do_read(i);

        // Randomized traffic
        rdy_mode = 1;
        for (int k = 0; k < 400; k++) begin
            int op;
            int w;
            op = $urandom_range(0, 2);
            w  = ($urandom_range(0, 19) == 0) ? N + 9 : $urandom_range(0, N + 1);
            if (op == 0) do_read(w);
            else wr(w, $urandom, 4'($urandom));
        end

        // Drain
        for (int c = 0; c < 200 && (m_pending || q_data.size() != 0); c++) @(posedge hclk);
        #1;
        chk("drained", {31'b0, m_pending || q_data.size() != 0}, 32'h0);
        rdy_mode = 0;
        repeat (2) @(posedge hclk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
